// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master Avalon-MM RAM arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic {GRANT_INSTR, GRANT_DATA} grant_t;

  localparam logic [3:0] BE_ALL = 4'b1111;

  // Slave-side request latched for the whole transaction
  typedef struct packed {
    logic [31:0] address;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        read;
    logic        write;
  } req_t;

endpackage

// File: rtl/avalon_mem_arbiter_if.sv
// One Avalon-MM port: address/control from master, waitrequest/readdata from slave.
interface avalon_mem_arbiter_if;
  logic [31:0] address;
  logic [3:0]  byteenable;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata
  );
endinterface

// File: rtl/avalon_mem_arbiter_rr_select2.sv
// Two-way round-robin pick: on contention the master not granted last wins.
module rr_select2
  import mem_arb_pkg::*;
(
  input  logic   req_i,
  input  logic   req_d,
  input  grant_t last_grant,
  output logic   valid,
  output grant_t grant
);

  always_comb begin
    valid = req_i | req_d;
    grant = GRANT_DATA;
    if (req_i && req_d)
      grant = (last_grant == GRANT_INSTR) ? GRANT_DATA : GRANT_INSTR;
    else if (req_i)
      grant = GRANT_INSTR;
  end

endmodule

// File: rtl/avalon_mem_arbiter.sv
// Shares one Avalon-MM RAM between instruction-fetch and data masters,
// one transaction at a time, with an enforced idle cycle between transactions.
module avalon_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  avalon_mem_arbiter_if.slave  i_bus,
  avalon_mem_arbiter_if.slave  d_bus,
  avalon_mem_arbiter_if.master m_bus,
  output logic                 timeout
);

  state_t      state, state_n;
  grant_t      last_grant, sel_grant;
  logic        sel_valid;
  req_t        req_q;
  logic [31:0] wait_cnt;
  logic        done;

  rr_select2 u_rr (
    .req_i      (i_bus.read),
    .req_d      (d_bus.read | d_bus.write),
    .last_grant (last_grant),
    .valid      (sel_valid),
    .grant      (sel_grant)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (sel_valid) state_n = ISSUE;
      ISSUE:   state_n = WAIT;
      WAIT:    if (!m_bus.waitrequest) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // wait_cnt holds the number of WAIT cycles including the current one
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req_q      <= '0;
      last_grant <= GRANT_DATA;
      wait_cnt   <= '0;
      timeout    <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (sel_valid) begin
          last_grant <= sel_grant;
          if (sel_grant == GRANT_INSTR) begin
            req_q.address    <= i_bus.address;
            req_q.byteenable <= BE_ALL;
            req_q.writedata  <= '0;
            req_q.read       <= 1'b1;
            req_q.write      <= 1'b0;
          end else begin
            req_q.address    <= d_bus.address;
            req_q.byteenable <= d_bus.byteenable;
            req_q.writedata  <= d_bus.writedata;
            req_q.read       <= d_bus.read & ~d_bus.write;
            req_q.write      <= d_bus.write;
          end
        end
        ISSUE: wait_cnt <= 32'd1;
        WAIT: begin
          if (m_bus.waitrequest) begin
            wait_cnt <= wait_cnt + 32'd1;
            if (WAIT_TIMEOUT != 0 && wait_cnt == 32'(WAIT_TIMEOUT))
              timeout <= 1'b1;
          end else begin
            req_q.read  <= 1'b0;
            req_q.write <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    done              = (state == WAIT) && !m_bus.waitrequest;
    i_bus.waitrequest = !(done && last_grant == GRANT_INSTR);
    d_bus.waitrequest = !(done && last_grant == GRANT_DATA);
  end

  assign i_bus.readdata   = m_bus.readdata;
  assign d_bus.readdata   = m_bus.readdata;
  assign m_bus.address    = req_q.address;
  assign m_bus.byteenable = req_q.byteenable;
  assign m_bus.writedata  = req_q.writedata;
  assign m_bus.read       = req_q.read;
  assign m_bus.write      = req_q.write;

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// Directed checks of arbitration, latching, idle gap, reset abort and timeout.
module tb_avalon_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic timeout;
  int   n_vec = 0;
  int   n_err = 0;

  avalon_mem_arbiter_if i_bus ();
  avalon_mem_arbiter_if d_bus ();
  avalon_mem_arbiter_if m_bus ();

  avalon_mem_arbiter #(.WAIT_TIMEOUT(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_bus   (i_bus),
    .d_bus   (d_bus),
    .m_bus   (m_bus),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_bus.read = 0; i_bus.write = 0; i_bus.address = '0; i_bus.byteenable = '0; i_bus.writedata = '0;
    d_bus.read = 0; d_bus.write = 0; d_bus.address = '0; d_bus.byteenable = '0; d_bus.writedata = '0;
    m_bus.waitrequest = 1'b1; m_bus.readdata = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_i;
    do_reset();
    #1;
    chk("rst_m_read",  m_bus.read, 0);
    chk("rst_m_write", m_bus.write, 0);
    chk("rst_m_addr",  m_bus.address, 0);
    chk("rst_m_be",    m_bus.byteenable, 0);
    chk("rst_m_wd",    m_bus.writedata, 0);
    chk("rst_i_wr",    i_bus.waitrequest, 1);
    chk("rst_d_wr",    d_bus.waitrequest, 1);
    chk("rst_timeout", timeout, 0);

    // single instruction read, request dropped after grant
    i_bus.read = 1; i_bus.address = 32'hBFC00000; m_bus.readdata = 32'h00211021;
    #1;
    chk("ird_idle_mread", m_bus.read, 0);
    chk("ird_idle_iwr",   i_bus.waitrequest, 1);
    tick();
    i_bus.read = 0; i_bus.address = '0; m_bus.waitrequest = 0;
    #1;
    chk("ird_issue_mread", m_bus.read, 1);
    chk("ird_issue_addr",  m_bus.address, 32'hBFC00000);
    chk("ird_issue_be",    m_bus.byteenable, 4'hF);
    chk("ird_issue_iwr",   i_bus.waitrequest, 1);
    tick(); #1;
    chk("ird_wait_mread", m_bus.read, 1);
    chk("ird_wait_iwr",   i_bus.waitrequest, 0);
    chk("ird_wait_rdata", i_bus.readdata, 32'h00211021);
    chk("ird_wait_dwr",   d_bus.waitrequest, 1);
    tick(); #1;
    chk("ird_gap_mread", m_bus.read, 0);
    chk("ird_gap_iwr",   i_bus.waitrequest, 1);
    m_bus.waitrequest = 1;

    // data write with 4 wait states; fields changed after grant
    d_bus.write = 1; d_bus.address = 32'hBFC00010; d_bus.byteenable = 4'b0011; d_bus.writedata = 32'hDEADBEEF;
    tick();
    d_bus.write = 0; d_bus.address = 32'h1234; d_bus.byteenable = 4'hF; d_bus.writedata = '0;
    #1;
    chk("dwr_issue_mwrite", m_bus.write, 1);
    chk("dwr_issue_mread",  m_bus.read, 0);
    for (int k = 1; k <= 4; k++) begin
      tick(); #1;
      chk($sformatf("dwr_w%0d_addr", k),  m_bus.address, 32'hBFC00010);
      chk($sformatf("dwr_w%0d_be", k),    m_bus.byteenable, 4'b0011);
      chk($sformatf("dwr_w%0d_wd", k),    m_bus.writedata, 32'hDEADBEEF);
      chk($sformatf("dwr_w%0d_write", k), m_bus.write, 1);
      chk($sformatf("dwr_w%0d_dwr", k),   d_bus.waitrequest, 1);
      chk($sformatf("dwr_w%0d_iwr", k),   i_bus.waitrequest, 1);
      chk($sformatf("dwr_w%0d_tmo", k),   timeout, (k == 4) ? 1 : 0);
    end
    tick();
    m_bus.waitrequest = 0;
    #1;
    chk("dwr_done_dwr",   d_bus.waitrequest, 0);
    chk("dwr_done_iwr",   i_bus.waitrequest, 1);
    chk("dwr_done_write", m_bus.write, 1);
    tick(); #1;
    chk("dwr_gap_write", m_bus.write, 0);
    chk("dwr_gap_dwr",   d_bus.waitrequest, 1);
    chk("dwr_tmo_sticky", timeout, 1);
    do_reset();
    #1;
    chk("tmo_cleared", timeout, 0);

    // contention: alternate I, D, I, D starting with INSTR
    i_bus.read = 1; i_bus.address = 32'h200;
    d_bus.read = 1; d_bus.address = 32'h100; d_bus.byteenable = 4'b0101;
    m_bus.waitrequest = 0;
    for (int k = 0; k < 4; k++) begin
      exp_i = (k % 2 == 0);
      #1;
      chk($sformatf("cont%0d_gap", k), m_bus.read, 0);
      tick(); #1;
      chk($sformatf("cont%0d_addr", k), m_bus.address, exp_i ? 32'h200 : 32'h100);
      chk($sformatf("cont%0d_be", k),   m_bus.byteenable, exp_i ? 4'hF : 4'b0101);
      tick(); #1;
      chk($sformatf("cont%0d_iwr", k), i_bus.waitrequest, exp_i ? 0 : 1);
      chk($sformatf("cont%0d_dwr", k), d_bus.waitrequest, exp_i ? 1 : 0);
      tick();
    end
    i_bus.read = 0; d_bus.read = 0;
    do_reset();

    // read+write together is a write
    d_bus.read = 1; d_bus.write = 1; d_bus.address = 32'h40; m_bus.waitrequest = 0;
    tick();
    d_bus.read = 0; d_bus.write = 0;
    #1;
    chk("rw_write", m_bus.write, 1);
    chk("rw_read",  m_bus.read, 0);
    tick(); #1;
    chk("rw_done_dwr", d_bus.waitrequest, 0);
    tick();
    do_reset();

    // reset during WAIT abandons the transaction
    i_bus.read = 1; i_bus.address = 32'h80;
    tick(); tick();
    i_bus.read = 0;
    #1;
    chk("rmw_pre_mread", m_bus.read, 1);
    reset = 1;
    tick();
    reset = 0; m_bus.waitrequest = 0;
    #1;
    chk("rmw_mread", m_bus.read, 0);
    chk("rmw_addr",  m_bus.address, 0);
    chk("rmw_iwr",   i_bus.waitrequest, 1);
    chk("rmw_dwr",   d_bus.waitrequest, 1);
    tick(); #1;
    chk("rmw_iwr2",  i_bus.waitrequest, 1);
    chk("rmw_mread2", m_bus.read, 0);
    do_reset();

    // timeout with a slave that never completes
    i_bus.read = 1; i_bus.address = 32'h300;
    tick();
    i_bus.read = 0;
    for (int k = 1; k <= 3; k++) begin
      tick(); #1;
      chk($sformatf("tmo_w%0d", k), timeout, 0);
    end
    tick(); #1;
    chk("tmo_set", timeout, 1);
    for (int k = 0; k < 10; k++) tick();
    #1;
    chk("tmo_hold", timeout, 1);
    chk("tmo_hold_mread", m_bus.read, 1);
    chk("tmo_hold_iwr", i_bus.waitrequest, 1);
    do_reset();
    #1;
    chk("tmo_rst", timeout, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
